// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
package game_pkg;

  // State encoding is visible on the controller's state output.
  typedef enum logic [1:0] {
    ST_TITLE   = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  // USB HID usage codes for the default control keys.
  localparam logic [7:0] KEYCODE_EMPTY = 8'h00;
  localparam logic [7:0] KEYCODE_SPACE = 8'h2C;
  localparam logic [7:0] KEYCODE_B     = 8'h05;
  localparam logic [7:0] KEYCODE_P     = 8'h13;

  // Width of the OVER hold counter; at least one bit even when the hold is zero frames.
  function automatic int unsigned over_cnt_width(input int unsigned frames);
    if (frames == 0) begin
      return 1;
    end
    return $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Detects one key code across all keycode slots and produces a one-frame press edge.
module key_edge_detect #(
  parameter int unsigned NUM_KEYS = 6,
  parameter logic [7:0]  KEY      = 8'h00
) (
  input  logic                  i_frame_clk,
  input  logic                  i_reset,
  input  logic [8*NUM_KEYS-1:0] i_keycodes,
  output logic                  o_hit,
  output logic                  o_press
);

  logic w_hit;
  logic r_hit_q;

  // OR-reduce slot matches so a key duplicated in several slots still reads as one hit.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if ((KEY != 8'h00) && (i_keycodes[8*k +: 8] == KEY)) begin
        w_hit = 1'b1;
      end
    end
  end

  // History clears on reset, so a key held through reset edges on the first frame;
  // the FSM decides whether that edge matters (only start acts from TITLE).
  always_ff @(posedge i_frame_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hit_q <= 1'b0;
    end else begin
      r_hit_q <= w_hit;
    end
  end

  // Rising edge of the hit level.
  always_comb begin
    o_hit   = w_hit;
    o_press = w_hit & ~r_hit_q;
  end

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game-flow controller: turns key presses and lives into TITLE/PLAYING/PAUSED/OVER
// sequencing with registered one-frame start/back pulses and level flags.
module game_flow_fsm
  import game_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 6,
  parameter int unsigned LIFE_W      = 2,
  parameter logic [7:0]  KEY_START   = KEYCODE_SPACE,
  parameter logic [7:0]  KEY_BACK    = KEYCODE_B,
  parameter logic [7:0]  KEY_PAUSE   = KEYCODE_P,
  parameter int unsigned OVER_FRAMES = 120
) (
  input  logic                  i_frame_clk,
  input  logic                  i_reset,
  input  logic [8*NUM_KEYS-1:0] i_keycodes,
  input  logic [LIFE_W-1:0]     i_life,
  output game_state_t           o_state,
  output logic                  o_start,
  output logic                  o_back,
  output logic                  o_run_en,
  output logic                  o_paused,
  output logic                  o_game_over
);

  localparam int unsigned CNT_W = over_cnt_width(OVER_FRAMES);

  game_state_t      r_state;
  game_state_t      w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_start;
  logic             w_start_d;
  logic             r_back;
  logic             w_back_d;

  logic w_press_start;
  logic w_press_back;
  logic w_press_pause;
  logic w_hit_start;
  logic w_hit_back;
  logic w_hit_pause;
  logic w_unused_hits;

  // Hit levels are exported by the detector but only the edges drive the flow.
  assign w_unused_hits = w_hit_start ^ w_hit_back ^ w_hit_pause;

  key_edge_detect #(
    .NUM_KEYS (NUM_KEYS),
    .KEY      (KEY_START)
  ) u_key_start (
    .i_frame_clk (i_frame_clk),
    .i_reset     (i_reset),
    .i_keycodes  (i_keycodes),
    .o_hit       (w_hit_start),
    .o_press     (w_press_start)
  );

  key_edge_detect #(
    .NUM_KEYS (NUM_KEYS),
    .KEY      (KEY_BACK)
  ) u_key_back (
    .i_frame_clk (i_frame_clk),
    .i_reset     (i_reset),
    .i_keycodes  (i_keycodes),
    .o_hit       (w_hit_back),
    .o_press     (w_press_back)
  );

  key_edge_detect #(
    .NUM_KEYS (NUM_KEYS),
    .KEY      (KEY_PAUSE)
  ) u_key_pause (
    .i_frame_clk (i_frame_clk),
    .i_reset     (i_reset),
    .i_keycodes  (i_keycodes),
    .o_hit       (w_hit_pause),
    .o_press     (w_press_pause)
  );

  // State, OVER hold counter and pulse registers.
  always_ff @(posedge i_frame_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_TITLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_back  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_start <= w_start_d;
      r_back  <= w_back_d;
    end
  end

  // Next-state: pulses default low so they last exactly one frame.
  // Priority: life==0 (PLAYING only) > back > pause > start.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_start_d = 1'b0;
    w_back_d  = 1'b0;
    case (r_state)
      ST_TITLE: begin
        if (w_press_start) begin
          w_state_d = ST_PLAYING;
          w_start_d = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (i_life == '0) begin
          w_state_d = ST_OVER;
          w_cnt_d   = CNT_W'(OVER_FRAMES);
        end else if (w_press_back) begin
          w_state_d = ST_TITLE;
          w_back_d  = 1'b1;
        end else if (w_press_pause) begin
          w_state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        // Game is frozen here, so life is not examined.
        if (w_press_back) begin
          w_state_d = ST_TITLE;
          w_back_d  = 1'b1;
        end else if (w_press_pause) begin
          w_state_d = ST_PLAYING;
        end
      end
      ST_OVER: begin
        if (w_press_back) begin
          w_state_d = ST_TITLE;
          w_back_d  = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_d = ST_TITLE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = ST_TITLE;
      end
    endcase
  end

  // Outputs decode purely from registered state, so they are glitch-free.
  always_comb begin
    o_state     = r_state;
    o_start     = r_start;
    o_back      = r_back;
    o_run_en    = (r_state == ST_PLAYING);
    o_paused    = (r_state == ST_PAUSED);
    o_game_over = (r_state == ST_OVER);
  end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed self-checking bench for game_flow_fsm (OVER_FRAMES = 4).
module tb_game_flow_fsm;
  import game_pkg::*;

  logic        clk;
  logic        rst;
  logic [47:0] keys;
  logic [1:0]  life;
  game_state_t state;
  logic        start;
  logic        back;
  logic        run_en;
  logic        paused;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  game_flow_fsm #(
    .NUM_KEYS    (6),
    .LIFE_W      (2),
    .KEY_START   (8'h2C),
    .KEY_BACK    (8'h05),
    .KEY_PAUSE   (8'h13),
    .OVER_FRAMES (4)
  ) dut (
    .i_frame_clk (clk),
    .i_reset     (rst),
    .i_keycodes  (keys),
    .i_life      (life),
    .o_state     (state),
    .o_start     (start),
    .o_back      (back),
    .o_run_en    (run_en),
    .o_paused    (paused),
    .o_game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one frame and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(ST_TITLE));
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_back"}, 32'(back), 0);
    chk({tag, "_run_en"}, 32'(run_en), 0);
    chk({tag, "_paused"}, 32'(paused), 0);
    chk({tag, "_game_over"}, 32'(game_over), 0);
  endtask

  initial begin
    int pulses;
    rst  = 1'b1;
    keys = '0;
    life = 2'd3;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Start held 5 frames: one pulse, PLAYING.
    keys   = 48'h00_00_00_00_00_2C;
    pulses = 0;
    tick();
    chk("start_first", 32'(start), 1);
    chk("start_state", 32'(state), 32'(ST_PLAYING));
    chk("start_run_en", 32'(run_en), 1);
    pulses += int'(start);
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(start);
    end
    chk("start_pulse_count", 32'(pulses), 1);
    keys = '0;
    tick();

    // Pause in slot 3, toggle twice.
    keys = 48'h00_00_13_00_00_00;
    tick();
    chk("pause_state", 32'(state), 32'(ST_PAUSED));
    chk("pause_flag", 32'(paused), 1);
    chk("pause_run_en", 32'(run_en), 0);
    keys = '0;
    tick();
    keys = 48'h00_00_13_00_00_00;
    tick();
    chk("unpause_state", 32'(state), 32'(ST_PLAYING));
    keys = '0;
    tick();

    // Held pause toggles once.
    keys = 48'h00_00_13_00_00_00;
    for (int i = 0; i < 10; i++) tick();
    chk("pause_hold_state", 32'(state), 32'(ST_PAUSED));
    keys = '0;
    tick();
    keys = 48'h00_00_13_00_00_00;
    tick();
    chk("pause_hold_resume", 32'(state), 32'(ST_PLAYING));
    keys = '0;
    tick();

    // Back beats pause in the same frame.
    keys = 48'h00_00_00_00_05_13;
    tick();
    chk("back_prio_state", 32'(state), 32'(ST_TITLE));
    chk("back_prio_pulse", 32'(back), 1);
    keys = '0;
    tick();
    chk("back_prio_clear", 32'(back), 0);

    // Start duplicated in all slots: single pulse.
    keys = {6{8'h2C}};
    tick();
    chk("dup_start_pulse", 32'(start), 1);
    chk("dup_start_state", 32'(state), 32'(ST_PLAYING));
    tick();
    chk("dup_start_clear", 32'(start), 0);
    keys = '0;
    tick();

    // life==0 beats back; OVER holds 4+1 frames then returns without back.
    life = 2'd0;
    keys = 48'h00_00_00_00_05_00;
    tick();
    chk("over_entry_state", 32'(state), 32'(ST_OVER));
    chk("over_entry_flag", 32'(game_over), 1);
    chk("over_entry_back", 32'(back), 0);
    keys   = '0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(back);
    end
    chk("over_hold_state", 32'(state), 32'(ST_OVER));
    tick();
    pulses += int'(back);
    chk("over_expire_state", 32'(state), 32'(ST_TITLE));
    chk("over_expire_no_back", 32'(pulses), 0);

    // OVER, back pressed at counter==2.
    life = 2'd3;
    keys = 48'h00_00_00_00_00_2C;
    tick();
    keys = '0;
    tick();
    life = 2'd0;
    tick();
    chk("over2_entry", 32'(state), 32'(ST_OVER));
    life = 2'd3;
    tick();
    tick();
    keys = 48'h00_00_00_00_05_00;
    tick();
    chk("over_back_state", 32'(state), 32'(ST_TITLE));
    chk("over_back_pulse", 32'(back), 1);
    keys = '0;
    tick();
    chk("over_back_clear", 32'(back), 0);

    // Reset mid-PAUSED with a start press pending.
    keys = 48'h00_00_00_00_00_2C;
    tick();
    keys = '0;
    tick();
    keys = 48'h00_00_13_00_00_00;
    tick();
    chk("pre_reset_paused", 32'(state), 32'(ST_PAUSED));
    keys = 48'h00_00_00_00_00_2C;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    #2;
    rst = 1'b0;

    // Start held through reset edges on the first frame.
    tick();
    chk("quick_restart_state", 32'(state), 32'(ST_PLAYING));
    chk("quick_restart_start", 32'(start), 1);

    // Reset during the start pulse drops it at once.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("pulse_reset");
    keys = '0;
    tick();
    #2;
    rst = 1'b0;
    tick();
    chk("final_state", 32'(state), 32'(ST_TITLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
